// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: redirect input, instruction-memory request/grant/response
// port and the decode-facing valid/ready output.
interface if_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [31:0]       out_instr;
  logic              out_exc;

  // Handshakes: a request transfers on a cycle with imem_req & imem_gnt, and
  // imem_addr holds while imem_req waits; an entry leaves the queue on a cycle
  // with out_valid & out_ready; responses return in request order.
  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_instr, out_exc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_instr, out_exc
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: sequential PC stream, credit-limited memory requests,
// DEPTH-entry fetch queue, redirect with stale-response discard, AdEL tagging.
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0040_0000,
  parameter int                DEPTH    = 4
) (
  input  logic           clk,
  input  logic           reset,
  if_fetch_unit_if.master bus,
  output logic           dbg_state
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Extra headroom: stale responses from earlier redirects sit on top of DEPTH live ones.
  localparam int FW = PW + 3;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc, rsp_pc;
  logic [FW-1:0]     inflight, stale, used;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr, wr_ptr;

  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [31:0]       q_instr [DEPTH];
  logic              q_exc   [DEPTH];

  logic              redirect, misaligned, req, grant, rsp, push, pop, out_valid;
  logic              wr_en, wr_exc;
  logic [PW-1:0]     wr_idx;
  logic [ADDR_W-1:0] wr_pc;
  logic [31:0]       wr_instr;

  assign redirect   = bus.redirect_valid;
  assign misaligned = bus.redirect_pc[1:0] != 2'b00;
  assign used       = inflight - stale + FW'(count);
  assign req        = reset && (state_q == RUN) && !redirect && (used < FW'(DEPTH));
  assign grant      = req && bus.imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp        = bus.imem_rvalid && (inflight != '0);
  assign push       = rsp && (stale == '0) && !redirect;
  assign out_valid  = count != '0;
  assign pop        = out_valid && bus.out_ready && !redirect;

  always_comb begin
    state_d = state_q;
    if (redirect) state_d = misaligned ? HALT : RUN;
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      stale    <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect) begin
      // Everything still outstanding belongs to the old stream.
      fetch_pc <= bus.redirect_pc;
      rsp_pc   <= bus.redirect_pc;
      inflight <= inflight - FW'(rsp);
      stale    <= inflight - FW'(rsp);
      rd_ptr   <= '0;
      wr_ptr   <= misaligned ? PW'(1) : '0;
      count    <= misaligned ? CW'(1) : '0;
    end else begin
      if (grant) fetch_pc <= fetch_pc + ADDR_W'(4);
      inflight <= inflight + FW'(grant) - FW'(rsp);
      if (rsp && (stale != '0)) stale <= stale - FW'(1);
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        rsp_pc <= rsp_pc + ADDR_W'(4);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = wr_ptr;
    wr_pc    = rsp_pc;
    wr_instr = bus.imem_rdata;
    wr_exc   = 1'b0;
    if (reset && redirect && misaligned) begin
      wr_en    = 1'b1;
      wr_idx   = '0;
      wr_pc    = bus.redirect_pc;
      wr_instr = '0;
      wr_exc   = 1'b1;
    end else if (reset && push) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      q_pc[wr_idx]    <= wr_pc;
      q_instr[wr_idx] <= wr_instr;
      q_exc[wr_idx]   <= wr_exc;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_valid ? q_pc[rd_ptr]    : '0;
  assign bus.out_instr = out_valid ? q_instr[rd_ptr] : '0;
  assign bus.out_exc   = out_valid ? q_exc[rd_ptr]   : 1'b0;
  assign dbg_state     = (state_q == HALT);
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Parametrised instruction-fetch unit for the cqu_mips five-stage pipeline. It generates the sequential PC stream and issues requests to instruction memory over a request/grant port. In-order responses are buffered in a DEPTH-entry fetch queue and delivered to decode over a valid/ready handshake. It adds the following on top of a plain PC/instruction register: branch/exception redirect with flush of stale in-flight responses, back-pressure, configurable reset vector, and misaligned-fetch exception tagging.

## Interface
- ADDR_W, 32, PC and memory address width
- RESET_PC, 32'h00400000, first fetch address after reset
- DEPTH, 4, fetch-queue entries and maximum in-flight requests (power of two, ≥2)
- clk  in  1  clock; one clock; reset is synchronous and active-low
- reset  in  1  synchronous active-low reset; sampled on rising clk
- redirect_valid  in  1  one-cycle redirect pulse (branch/jump/exception)
- redirect_pc  in  ADDR_W  new fetch address
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  word-aligned fetch address
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  in-order response valid, ≥1 cycle after grant
- imem_rdata  in  32  instruction word
- out_valid  out  1  queue head valid for decode
- out_ready  in  1  decode accepts head
- out_pc  out  ADDR_W  PC of head instruction
- out_instr  out  32  head instruction (0 when out_exc)
- out_exc  out  1  head is a fetch address-error (AdEL) marker

## Operation
- Registers: fetch_pc (next request address), rsp_pc (PC of next expected live response), inflight (granted, unanswered), stale (subset of inflight to discard), queue (DEPTH × {pc, instr, exc}), state.
- States: RUN (issue sequential fetches); HALT (misaligned redirect taken, no fetches issued). HALT→RUN only on an aligned redirect. RUN→HALT on redirect_pc[1:0]≠0.
- Request: imem_req = (state==RUN) & ~redirect_valid & (inflight − stale + count < DEPTH). imem_addr = fetch_pc. Address is held stable while imem_req=1 until granted. On req&gnt: fetch_pc += 4 (mod 2^ADDR_W, wraps silently), inflight += 1.
- Response: imem_rvalid decrements inflight. If stale>0, decrement stale and drop the data. Otherwise push {rsp_pc, imem_rdata, 0} and increment rsp_pc by 4. Responses with inflight==0 are a protocol error and are ignored.
- Pop: out_valid & out_ready removes the head.
- Redirect (highest priority): the queue is flushed. Any pop, push, or grant that cycle is void. fetch_pc and rsp_pc take redirect_pc. stale takes inflight minus imem_rvalid, so every in-flight response is discarded. If misaligned: push a single {redirect_pc, 0, 1} entry and enter HALT.
- Credit rule: the queue never overflows because live in-flight requests plus entries never exceed DEPTH.
- Simultaneous push and pop when full is legal: count is unchanged.
- Reset values: imem_req=0 while reset=0; imem_addr=RESET_PC; out_valid=0; out_pc=0; out_instr=0; out_exc=0; inflight=stale=count=0; state=RUN.
- out_pc, out_instr, and out_exc read 0 whenever out_valid=0.
- Reset asserted mid-operation discards all state. Responses for requests granted before reset and arriving after it are not tracked. The memory side is reset together with this block.

## Timing
- First cycle after reset deasserts: imem_req=1, imem_addr=RESET_PC.
- Back-to-back grants sustain one fetch per cycle while credit remains.
- Response in cycle N gives out_valid=1 in cycle N+1. There is no combinational bypass from imem_rdata to out_*.
- Redirect in cycle N: imem_req=0 in N. The first request to redirect_pc is in N+1. out_valid=0 in N+1 (aligned case). out_valid=1 with out_exc=1 in N+1 (misaligned case).
- imem_req depends combinationally only on redirect_valid and registers. No other input-to-output combinational paths exist.

## Test plan
- Reset release, gnt held 1, 1-cycle memory latency, out_ready=1 → requests at 0x00400000, 0x00400004, …; outputs in order with matching out_pc, one per cycle.
- out_ready=0 for 10 cycles, DEPTH=4 → exactly 4 grants, imem_req drops to 0, queue holds 4 entries. Releasing out_ready drains them in order and fetching resumes at 0x00400010.
- Memory latency 3, redirect to 0x00400100 with 2 requests in flight → both stale responses dropped; next output is out_pc=0x00400100.
- Redirect in the same cycle as imem_rvalid and out_valid&out_ready → that response is discarded, stale=inflight−1, no duplicate or lost entry.
- Redirect to 0x00400102 → single entry with out_exc=1, out_pc=0x00400102, out_instr=0, imem_req stays 0. A later redirect to 0x00400200 resumes fetching.
- fetch_pc at 0xFFFFFFFC granted → next imem_addr=0x00000000; reset driven low mid-stream → all outputs return to reset values the next cycle.
